// File: rtl/alu_div_seq.sv
// Sequential restoring divider: one shared subtractor is reused for WIDTH iterations per divide.
// Optional signed (truncating) division is built only when ALU_DIV_SIGNED_EN is defined.
module alu_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef ALU_DIV_SIGNED_EN
  input  logic             sign_op,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic             accept;
  logic             last_iter;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH:0]   r_reg;
  logic [WIDTH-1:0] d_reg;
  logic [IW-1:0]    iter_reg;

  logic [WIDTH:0]   rs;
  logic [WIDTH+1:0] sum;
  logic             c_out;
  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             unused_r_msb;

  assign busy      = (state_reg == RUN);
  assign done      = (state_reg == DONE);
  assign last_iter = (iter_reg == IW'(WIDTH - 1));

  // Shared subtractor: a + ~b + 1, carry-out set means no borrow (Rs >= D).
  assign rs     = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
  assign sum    = {1'b0, rs} + {1'b0, ~{1'b0, d_reg}} + (WIDTH+2)'(1);
  assign c_out  = sum[WIDTH+1];
  assign r_step = c_out ? sum[WIDTH:0] : rs;
  assign q_step = {q_reg[WIDTH-2:0], c_out};

  // The partial remainder stays below D, so its top bit never feeds back.
  assign unused_r_msb = r_reg[WIDTH];

`ifdef ALU_DIV_SIGNED_EN
  logic a_neg, b_neg;
  logic neg_q_reg, neg_r_reg;

  assign a_neg = sign_op & dividend[WIDTH-1];
  assign b_neg = sign_op & divisor[WIDTH-1];
  assign a_mag = a_neg ? (~dividend + WIDTH'(1)) : dividend;
  assign b_mag = b_neg ? (~divisor + WIDTH'(1)) : divisor;
  assign q_fix = neg_q_reg ? (~q_step + WIDTH'(1)) : q_step;
  assign r_fix = neg_r_reg ? (~r_step[WIDTH-1:0] + WIDTH'(1)) : r_step[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else if (accept) begin
      neg_q_reg <= a_neg ^ b_neg;
      neg_r_reg <= a_neg;
    end
  end
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_fix = q_step;
  assign r_fix = r_step[WIDTH-1:0];
`endif

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (divisor == '0) ? DONE : RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN:     if (last_iter) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg       <= '0;
      r_reg       <= '0;
      d_reg       <= '0;
      iter_reg    <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      q_reg       <= a_mag;
      r_reg       <= '0;
      d_reg       <= b_mag;
      iter_reg    <= '0;
      div_by_zero <= (divisor == '0);
      // Zero divisor bypasses RUN, so results are published at accept.
      if (divisor == '0) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (state_reg == RUN) begin
      q_reg    <= q_step;
      r_reg    <= r_step;
      iter_reg <= iter_reg + IW'(1);
      if (last_iter) begin
        quotient  <= q_fix;
        remainder <= r_fix;
      end
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// Self-checking bench for alu_div_seq: vector table, corner sequences and randomized model checks.
module tb_alu_div_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
`ifdef ALU_DIV_SIGNED_EN
  logic         sign_op = 1'b0;
`endif
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           sg;
    bit           b2b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  always #5 clk = ~clk;

  alu_div_seq #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
`ifdef ALU_DIV_SIGNED_EN
    .sign_op(sign_op),
`endif
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division; signed uses 64-bit truncating arithmetic.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit sg,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa, sb, lq, lr;
    z = (b == 0);
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (!sg) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      lq = sa / sb;
      lr = sa % sb;
      q = lq[W-1:0];
      r = lr[W-1:0];
    end
  endfunction

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit sg, input bit b2b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                         input string tag);
    int cyc, nbusy;
    if (!b2b) @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
`ifdef ALU_DIV_SIGNED_EN
    sign_op  = sg;
`endif
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    nbusy = 0;
    while (!done && cyc < 100) begin
      if (busy) nbusy++;
      @(negedge clk);
      cyc++;
    end
    check({tag, " done"}, done, 1);
    check({tag, " latency"}, cyc, ez ? 1 : W + 1);
    check({tag, " busy_cycles"}, nbusy, ez ? 0 : W);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, div_by_zero, ez);
    $display("div %s: %h / %h sg=%0d -> q=%h r=%h z=%0d lat=%0d", tag, a, b, sg, quotient,
             remainder, div_by_zero, cyc);
  endtask

  vec_t tbl[10];

  initial begin
    logic [W-1:0] a, b, eq, er;
    logic         ez;
    int           nd;
    logic [W-1:0] cq, cr;

    tbl[0] = '{32'd100,        32'd7,          0, 0, 32'd14,         32'd2,        1'b0};
    tbl[1] = '{32'hFFFFFFFF,   32'd1,          0, 0, 32'hFFFFFFFF,   32'd0,        1'b0};
    tbl[2] = '{32'd5,          32'd9,          0, 1, 32'd0,          32'd5,        1'b0};
    tbl[3] = '{32'd5,          32'd0,          0, 0, 32'hFFFFFFFF,   32'd5,        1'b1};
    tbl[4] = '{32'd7,          32'd7,          0, 1, 32'd1,          32'd0,        1'b0};
    tbl[5] = '{32'd0,          32'd3,          0, 0, 32'd0,          32'd0,        1'b0};
    tbl[6] = '{32'hFFFFFFFF,   32'hFFFFFFFE,   0, 0, 32'd1,          32'd1,        1'b0};
    tbl[7] = '{32'h80000000,   32'd3,          0, 0, 32'h2AAAAAAA,   32'd2,        1'b0};
    tbl[8] = '{32'h12345678,   32'd0,          0, 0, 32'hFFFFFFFF,   32'h12345678, 1'b1};
    tbl[9] = '{32'hFFFFFFF9,   32'd2,          0, 1, 32'h7FFFFFFC,   32'd1,        1'b0};

    // Reset state
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset div_by_zero", div_by_zero, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_div(tbl[i].a, tbl[i].b, tbl[i].sg, tbl[i].b2b, tbl[i].q, tbl[i].r, tbl[i].z,
              $sformatf("vec%0d", i));

    // start during RUN must be ignored
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    dividend = 32'd8; divisor = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0; cq = '0; cr = '0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        nd++;
        cq = quotient;
        cr = remainder;
      end
      @(negedge clk);
    end
    check("ignore done_pulses", nd, 1);
    check("ignore quotient", cq, 14);
    check("ignore remainder", cr, 2);
    $display("div ignore: 100/7 with 8/2 during run -> q=%0d r=%0d pulses=%0d", cq, cr, nd);

    // Reset in the middle of RUN
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("midrun busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrun busy", busy, 0);
    check("midrun done", done, 0);
    check("midrun quotient", quotient, 0);
    check("midrun remainder", remainder, 0);
    check("midrun div_by_zero", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("midrun no_done", nd, 0);
    $display("div midrun reset: aborted, done pulses after reset=%0d", nd);
    run_div(32'd9, 32'd3, 0, 0, 32'd3, 32'd0, 1'b0, "after_reset");

`ifdef ALU_DIV_SIGNED_EN
    run_div(32'hFFFFFFF9, 32'd2,        1, 0, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, "s_neg7_2");
    run_div(32'd7,        32'hFFFFFFFE, 1, 0, 32'hFFFFFFFD, 32'd1,        1'b0, "s_7_neg2");
    run_div(32'hFFFFFFF9, 32'hFFFFFFFE, 1, 0, 32'd3,        32'hFFFFFFFF, 1'b0, "s_neg7_neg2");
    run_div(32'h80000000, 32'hFFFFFFFF, 1, 0, 32'h80000000, 32'd0,        1'b0, "s_min_neg1");
    run_div(32'hFFFFFFFB, 32'd0,        1, 0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, "s_neg5_0");
    for (int i = 0; i < 15; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : ($urandom >> $urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) b = ~b + 1;
      ref_div(a, b, 1, eq, er, ez);
      run_div(a, b, 1, $urandom_range(0, 1), eq, er, ez, $sformatf("srand%0d", i));
    end
`endif

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : ($urandom >> $urandom_range(0, 31));
      ref_div(a, b, 0, eq, er, ez);
      run_div(a, b, 0, $urandom_range(0, 1), eq, er, ez, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
